// File: rtl/bsg_parallel_in_serial_out_const_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bsg_parallel_in_serial_out_const_pkg
// Brief   : Shared helpers for the constant-ratio PISO (safe clog2 sizing).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package bsg_parallel_in_serial_out_const_pkg;

    // clog2 that never returns 0, so a 1-entry index still gets a 1-bit field
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_piso_const_buf.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bsg_piso_const_buf
// Brief   : Array FIFO of depth 1 or 2. valid/ready_and in, valid/yumi out.
//           Asynchronous active-low reset clears occupancy only; payload
//           storage is not reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module bsg_piso_const_buf #(
    parameter int els_p   = 2,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_and_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    if (els_p == 1) begin : g_single
        logic               r_full;
        logic [width_p-1:0] r_data;
        logic               w_push;

        // A single entry cannot be refilled in the cycle it drains, which
        // is the source of the one-cycle bubble in minimal mode.
        assign w_push = v_i & ~r_full;

        // Occupancy flag
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i)  r_full <= 1'b0;
            else if (w_push) r_full <= 1'b1;
            else if (yumi_i) r_full <= 1'b0;
        end

        // Payload capture
        always_ff @(posedge clk_i) begin
            if (w_push) r_data <= data_i;
        end

        assign ready_and_o = ~r_full;
        assign v_o         = r_full;
        assign data_o      = r_data;
    end else begin : g_double
        logic [1:0]         r_cnt;
        logic               r_wptr;
        logic               r_rptr;
        logic [width_p-1:0] r_mem [2];
        logic               w_push;

        assign w_push = v_i & (r_cnt != 2'd2);

        // Occupancy and ring pointers; push and pop may coincide
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_cnt  <= 2'd0;
                r_wptr <= 1'b0;
                r_rptr <= 1'b0;
            end else begin
                r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, yumi_i};
                if (w_push) r_wptr <= ~r_wptr;
                if (yumi_i) r_rptr <= ~r_rptr;
            end
        end

        // Payload capture into the tail entry
        always_ff @(posedge clk_i) begin
            if (w_push) r_mem[r_wptr] <= data_i;
        end

        assign ready_and_o = (r_cnt != 2'd2);
        assign v_o         = (r_cnt != 2'd0);
        assign data_o      = r_mem[r_rptr];
    end

endmodule
`default_nettype wire

// File: rtl/bsg_parallel_in_serial_out_const.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : bsg_parallel_in_serial_out_const
// Brief   : Buffered parallel-in/serial-out converter with a constant ratio.
//           Accepts els_p words per input handshake and emits one word per
//           yumi, lowest index first unless hi_to_lo_p=1.
//           Optional macro BSG_PISO_CONST_PARTIAL_EN adds len_i (index of the
//           final word) stored with each array.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module bsg_parallel_in_serial_out_const
    import bsg_parallel_in_serial_out_const_pkg::*;
#(
    parameter int width_p                 = 8,
    parameter int els_p                   = 4,
    parameter int hi_to_lo_p              = 0,
    parameter int use_minimal_buffering_p = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    output logic                       ready_and_o,
    input  logic [els_p*width_p-1:0]   data_i,
`ifdef BSG_PISO_CONST_PARTIAL_EN
    input  logic [safe_clog2(els_p)-1:0] len_i,
`endif
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic                       last_o,
    input  logic                       yumi_i
);

    localparam int c_CNT_W  = safe_clog2(els_p);
    localparam int c_DEPTH  = (use_minimal_buffering_p != 0) ? 1 : 2;
    localparam int c_DATA_W = els_p * width_p;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(els_p - 1);

`ifdef BSG_PISO_CONST_PARTIAL_EN
    localparam int c_BUF_W = c_DATA_W + c_CNT_W;
`else
    localparam int c_BUF_W = c_DATA_W;
`endif

    logic                             w_buf_ready;
    logic                             w_buf_v;
    logic [c_BUF_W-1:0]               w_buf_in;
    logic [c_BUF_W-1:0]               w_buf_out;
    logic [els_p-1:0][width_p-1:0]    w_head;
    logic [c_CNT_W-1:0]               w_last_idx;
    logic                             w_last;
    logic [width_p-1:0]               w_word;
    logic [c_CNT_W-1:0]               r_cnt;

`ifdef BSG_PISO_CONST_PARTIAL_EN
    assign w_buf_in   = {len_i, data_i};
    assign w_head     = w_buf_out[c_DATA_W-1:0];
    assign w_last_idx = w_buf_out[c_BUF_W-1:c_DATA_W];
`else
    assign w_buf_in   = data_i;
    assign w_head     = w_buf_out;
    assign w_last_idx = c_LAST_IDX;
`endif

    bsg_piso_const_buf #(
        .els_p   (c_DEPTH),
        .width_p (c_BUF_W)
    ) u_buf (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .v_i         (v_i),
        .ready_and_o (w_buf_ready),
        .data_i      (w_buf_in),
        .v_o         (w_buf_v),
        .data_o      (w_buf_out),
        .yumi_i      (yumi_i & w_last)
    );

    assign w_last = w_buf_v & (r_cnt == w_last_idx);

    // Word counter: explicit wrap at the final word of the head array
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= '0;
        end else if (yumi_i) begin
            if (w_last) r_cnt <= '0;
            else        r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Output word select; reversed index order when hi_to_lo_p is set
    always_comb begin
        w_word = '0;
        for (int i = 0; i < els_p; i++) begin
            if (int'(r_cnt) == i) begin
                w_word = w_head[(hi_to_lo_p != 0) ? (els_p - 1 - i) : i];
            end
        end
    end

    // Ready is held low for the whole time reset is asserted
    assign ready_and_o = reset_n_i & w_buf_ready;
    assign v_o         = w_buf_v;
    assign data_o      = w_word;
    assign last_o      = w_last;

`ifndef SYNTHESIS
    // Consumer protocol: yumi only against a valid word
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_o))
                else $error("yumi_i asserted while v_o is low");
        end
    end
`ifdef BSG_PISO_CONST_PARTIAL_EN
    // Producer protocol: len_i must index a word inside the array
    always @(posedge clk_i) begin
        if (reset_n_i && v_i) begin
            assert (int'(len_i) < els_p)
                else $error("len_i out of range: %0d", len_i);
        end
    end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_parallel_in_serial_out_const.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_bsg_parallel_in_serial_out_const
// Brief   : Self-checking bench. Four instances: base (els 4, depth 2),
//           minimal buffering, hi_to_lo, and els 3. A word-level queue model
//           tracks expected words, last flags, held arrays and ready.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bsg_parallel_in_serial_out_const;

    typedef struct packed {
        logic [7:0] w;
        logic       l;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        vin   [4];
    logic        yin   [4];
    logic [31:0] din   [4];
    logic [1:0]  lenin [4];
    logic        vo    [4];
    logic        rdy   [4];
    logic        lst   [4];
    logic [7:0]  dout  [4];

    int          n_cmp;
    int          n_fail;
    exp_t        mq [$];
    logic [31:0] arr_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bsg_parallel_in_serial_out_const #(.width_p(8), .els_p(4), .hi_to_lo_p(0), .use_minimal_buffering_p(0)) u_base (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(vin[0]), .ready_and_o(rdy[0]), .data_i(din[0]),
`ifdef BSG_PISO_CONST_PARTIAL_EN
        .len_i(lenin[0]),
`endif
        .v_o(vo[0]), .data_o(dout[0]), .last_o(lst[0]), .yumi_i(yin[0]));

    bsg_parallel_in_serial_out_const #(.width_p(8), .els_p(4), .hi_to_lo_p(0), .use_minimal_buffering_p(1)) u_min (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(vin[1]), .ready_and_o(rdy[1]), .data_i(din[1]),
`ifdef BSG_PISO_CONST_PARTIAL_EN
        .len_i(lenin[1]),
`endif
        .v_o(vo[1]), .data_o(dout[1]), .last_o(lst[1]), .yumi_i(yin[1]));

    bsg_parallel_in_serial_out_const #(.width_p(8), .els_p(4), .hi_to_lo_p(1), .use_minimal_buffering_p(0)) u_hl (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(vin[2]), .ready_and_o(rdy[2]), .data_i(din[2]),
`ifdef BSG_PISO_CONST_PARTIAL_EN
        .len_i(lenin[2]),
`endif
        .v_o(vo[2]), .data_o(dout[2]), .last_o(lst[2]), .yumi_i(yin[2]));

    bsg_parallel_in_serial_out_const #(.width_p(8), .els_p(3), .hi_to_lo_p(0), .use_minimal_buffering_p(0)) u_e3 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(vin[3]), .ready_and_o(rdy[3]), .data_i(din[3][23:0]),
`ifdef BSG_PISO_CONST_PARTIAL_EN
        .len_i(lenin[3]),
`endif
        .v_o(vo[3]), .data_o(dout[3]), .last_o(lst[3]), .yumi_i(yin[3]));

    function automatic int els_of(input int k);
        return (k == 3) ? 3 : 4;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 1) ? 1 : 2;
    endfunction

    function automatic bit hl_of(input int k);
        return (k == 2);
    endfunction

    // Streams arr_q through instance k. len is the final-word index of every
    // array. pct is the per-cycle probability (percent) of yumi when valid.
    task automatic run_stream(input int k, input int n, input int pct, input int len,
                              output int bubbles, output int words);
        int          idx;
        int          cyc;
        int          held;
        int          total;
        bit          acc;
        logic [31:0] acc_arr;
        logic [31:0] tmp;
        exp_t        e;
        bit          y;
        mq.delete();
        idx = 0; cyc = 0; acc = 0; bubbles = 0; words = 0;
        acc_arr = '0;
        total = n * (len + 1);
        while (idx < n || acc || mq.size() > 0) begin
            @(negedge clk);
            // An array accepted at the previous edge becomes visible now
            if (acc) begin
                for (int j = 0; j <= len; j++) begin
                    int p;
                    p = hl_of(k) ? (els_of(k) - 1 - j) : j;
                    tmp = acc_arr >> (8 * p);
                    e.w = tmp[7:0];
                    e.l = (j == len);
                    mq.push_back(e);
                end
                acc = 0;
            end
            held = 0;
            foreach (mq[i]) if (mq[i].l) held++;
            n_cmp++;
            if (vo[k] !== (mq.size() > 0)) begin
                n_fail++;
                $display("FAIL v_o k=%0d t=%0t: got %b expected %b", k, $time, vo[k], mq.size() > 0);
            end
            n_cmp++;
            if (rdy[k] !== (held < depth_of(k))) begin
                n_fail++;
                $display("FAIL ready k=%0d t=%0t: got %b expected %b", k, $time, rdy[k], held < depth_of(k));
            end
            if (mq.size() > 0) begin
                n_cmp++;
                if (dout[k] !== mq[0].w || lst[k] !== mq[0].l) begin
                    n_fail++;
                    $display("FAIL word k=%0d t=%0t: got %h/last %b expected %h/last %b",
                             k, $time, dout[k], lst[k], mq[0].w, mq[0].l);
                end
            end
            if (words > 0 && words < total && vo[k] !== 1'b1) bubbles++;
            vin[k] = (idx < n);
            if (idx < n) begin
                din[k]   = arr_q[idx];
                lenin[k] = 2'(len);
                if (rdy[k] === 1'b1) begin
                    acc     = 1;
                    acc_arr = arr_q[idx];
                    idx++;
                end
            end
            y = (vo[k] === 1'b1) && ($urandom_range(99) < pct);
            yin[k] = y;
            if (y) begin
                if (mq.size() > 0) void'(mq.pop_front());
                words++;
            end
            cyc++;
            if (cyc > 500) begin
                n_fail++;
                $display("FAIL timeout k=%0d: %0d words seen, required %0d", k, words, total);
                break;
            end
        end
        @(negedge clk);
        vin[k] = 1'b0;
        yin[k] = 1'b0;
        n_cmp++;
        if (vo[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL drained k=%0d: v_o got %b required 0", k, vo[k]);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vin[k] = 0; yin[k] = 0; din[k] = '0; lenin[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (vo[k] !== 1'b0 || rdy[k] !== 1'b0 || lst[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset k=%0d: v/ready/last got %b%b%b required 000", k, vo[k], rdy[k], lst[k]);
            end
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rdy[k] !== 1'b1 || vo[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset k=%0d: ready/v got %b%b required 10", k, rdy[k], vo[k]);
            end
        end
    endtask

    task automatic test_basic();
        int b, w;
        arr_q.delete();
        arr_q.push_back(32'h44332211);
        run_stream(0, 1, 100, 3, b, w);
        n_cmp++;
        if (w != 4 || b != 0) begin
            n_fail++;
            $display("FAIL basic: words %0d bubbles %0d, required 4 and 0", w, b);
        end
    endtask

    task automatic test_reset_mid();
        int b, w;
        logic [7:0] exp_w [3];
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
        @(negedge clk);
        vin[0] = 1; din[0] = 32'h44332211;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vin[0] = 0;
            n_cmp++;
            if (vo[0] !== 1'b1 || dout[0] !== exp_w[c]) begin
                n_fail++;
                $display("FAIL mid_word%0d: v %b data %h, required 1 %h", c, vo[0], dout[0], exp_w[c]);
            end
            yin[0] = (c < 2);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (vo[0] !== 1'b0 || rdy[0] !== 1'b0 || lst[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: v/ready/last got %b%b%b required 000", vo[0], rdy[0], lst[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rdy[0] !== 1'b1 || vo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: ready/v got %b%b required 10", rdy[0], vo[0]);
        end
        arr_q.delete();
        arr_q.push_back(32'hDDCCBBAA);
        run_stream(0, 1, 100, 3, b, w);
    endtask

    task automatic test_back_to_back();
        int b, w;
        arr_q.delete();
        arr_q.push_back(32'h44332211);
        arr_q.push_back(32'h88776655);
        run_stream(0, 2, 100, 3, b, w);
        n_cmp++;
        if (w != 8 || b != 0) begin
            n_fail++;
            $display("FAIL back_to_back: words %0d bubbles %0d, required 8 and 0", w, b);
        end
    endtask

    task automatic test_min_buffering();
        int b, w;
        arr_q.delete();
        arr_q.push_back(32'h44332211);
        arr_q.push_back(32'h88776655);
        run_stream(1, 2, 100, 3, b, w);
        n_cmp++;
        if (w != 8 || b != 1) begin
            n_fail++;
            $display("FAIL min_buffering: words %0d bubbles %0d, required 8 and 1", w, b);
        end
    endtask

    task automatic test_hi_to_lo();
        int b, w;
        arr_q.delete();
        arr_q.push_back(32'h44332211);
        run_stream(2, 1, 100, 3, b, w);
        n_cmp++;
        if (w != 4) begin
            n_fail++;
            $display("FAIL hi_to_lo: words %0d, required 4", w);
        end
    endtask

    task automatic test_els3();
        int b, w;
        arr_q.delete();
        for (int i = 0; i < 3; i++) arr_q.push_back($urandom());
        run_stream(3, 3, 55, 2, b, w);
        n_cmp++;
        if (w != 9) begin
            n_fail++;
            $display("FAIL els3: words %0d, required 9", w);
        end
    endtask

    task automatic test_random();
        int b, w;
        for (int k = 0; k < 3; k++) begin
            arr_q.delete();
            for (int i = 0; i < 5; i++) arr_q.push_back($urandom());
            run_stream(k, 5, 40 + 15 * k, 3, b, w);
            n_cmp++;
            if (w != 20) begin
                n_fail++;
                $display("FAIL random k=%0d: words %0d, required 20", k, w);
            end
        end
    endtask

`ifdef BSG_PISO_CONST_PARTIAL_EN
    task automatic test_partial();
        int b, w;
        arr_q.delete();
        arr_q.push_back($urandom());
        arr_q.push_back($urandom());
        run_stream(3, 2, 70, 1, b, w);
        n_cmp++;
        if (w != 4) begin
            n_fail++;
            $display("FAIL partial: words %0d, required 4", w);
        end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_reset_mid();
        test_back_to_back();
        test_min_buffering();
        test_hi_to_lo();
        test_els3();
        test_random();
`ifdef BSG_PISO_CONST_PARTIAL_EN
        test_partial();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
